cksum_engine: RTL and testbench

Parametrised successor to the single-mode halfword checksum unit. It computes the 16-bit one's-complement Internet checksum over a byte field held in packet memory. The memory port is DATA_W wide, and several 16-bit lanes are summed per cycle. Two modes: GENERATE writes the checksum into a destination field; VERIFY checks a field in place and reports pass/fail. It sits beside the deparser/action unit on the shared packet-memory port and is driven by a level start / ready handshake.

---
 rtl/cksum_engine.sv | 104 ++++++++++
 tb/tb_cksum_engine.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cksum_engine.sv
// cksum_engine: multi-lane one's-complement Internet checksum generate/verify over packet memory
module cksum_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] field_start_i,
  input  logic [15:0]       field_len_i,
  input  logic [ADDR_W-1:0] dst_field_start_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic              ok_o
);
  localparam int LANES = DATA_W / 16;
  localparam int BYTES = DATA_W / 8;
  typedef enum logic [2:0] {FREE, CLEAR, SUM, FOLD, STORE, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_end;
  logic [ACC_W-1:0]  r_acc, w_lanes;
  logic [DATA_W-1:0] w_masked;
  logic [15:0]       r_sum, w_sum16;
  logic [16:0]       w_s;
  logic              r_mode, w_last, w_empty, w_wr;
  assign w_empty = field_len_i == 16'd0;
  assign w_last  = (r_addr + ADDR_W'(BYTES)) >= r_end;
  assign w_s     = 17'(r_acc[ACC_W-1:16]) + 17'(r_acc[15:0]);
  assign w_sum16 = w_s[15:0] + 16'(w_s[16]);
  assign w_wr    = r_state == CLEAR || r_state == STORE;
  assign busy_o  = r_state != FREE && r_state != DONE;
  // Zero bytes at or past the field end, then add all halfword lanes of this beat
  always_comb begin
    w_masked = '0;
    w_lanes  = '0;
    for (int k = 0; k < BYTES; k++)
      w_masked[DATA_W-1-8*k -: 8] = (r_addr + ADDR_W'(k) < r_end) ? mem_data_i[DATA_W-1-8*k -: 8] : 8'h00;
    for (int j = 0; j < LANES; j++)
      w_lanes = w_lanes + ACC_W'(w_masked[DATA_W-1-16*j -: 16]);
  end
  // Memory port is driven purely from state: clear write, reads, checksum write, else idle zeros
  always_comb begin
    mem_ce_o    = w_wr || r_state == SUM;
    mem_we_o    = w_wr;
    mem_addr_o  = r_state == SUM ? r_addr : w_wr ? dst_field_start_i : '0;
    mem_width_o = r_state == SUM ? 4'(BYTES) : w_wr ? 4'd2 : 4'd0;
    mem_data_o  = r_state == STORE ? DATA_W'(r_sum) : '0;
  end
  // Next-state logic; empty fields skip straight to the fold
  always_comb begin
    w_next = r_state;
    case (r_state)
      FREE:    w_next = !start_i ? FREE : !mode_i ? CLEAR : w_empty ? FOLD : SUM;
      CLEAR:   w_next = w_empty ? FOLD : SUM;
      SUM:     w_next = w_last ? FOLD : SUM;
      FOLD:    w_next = r_mode ? DONE : STORE;
      STORE:   w_next = DONE;
      DONE:    w_next = start_i ? DONE : FREE;
      default: w_next = FREE;
    endcase
  end
  // State register
  always_ff @(posedge clk) r_state <= rst ? FREE : w_next;
  // Datapath: field bounds, accumulation, fold result and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_end   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_mode  <= 1'b0;
      ready_o <= 1'b0;
      ok_o    <= 1'b0;
    end else if (r_state == FREE && start_i) begin
      r_mode  <= mode_i;
      r_addr  <= field_start_i;
      r_end   <= field_start_i + ADDR_W'(field_len_i);
      r_acc   <= '0;
      ready_o <= 1'b0;
      ok_o    <= 1'b0;
    end else if (r_state == SUM) begin
      r_acc  <= r_acc + w_lanes;
      r_addr <= r_addr + ADDR_W'(BYTES);
    end else if (r_state == FOLD) begin
      r_sum <= ~w_sum16;
      if (r_mode) begin
        ok_o    <= w_sum16 == 16'hFFFF;
        ready_o <= 1'b1;
      end
    end else if (r_state == STORE) begin
      ready_o <= 1'b1;
    end else if (r_state == DONE && !start_i) begin
      ready_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cksum_engine.sv
// tb_cksum_engine: scoreboard bench running DATA_W=16/32/64 engines side by side on directed vectors
module tb_cksum_engine;
  logic        clk = 0, rst = 1, start = 0, mode = 0;
  logic [31:0] fs = 0, dst = 0;
  logic [15:0] flen = 0;
  int          checks = 0, errors = 0, cyc = 0, t0 = 0;
  logic [7:0]  mem [3][256];
  logic [31:0] exp_w [3][$];
  logic [32:0] exp_r [3][$];
  logic [2:0]  rdy;
  logic [9:0]  outs [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int DW = 16 << g;
    localparam int BY = DW / 8;
    logic          ce, we, busy, ready, ok, ready_q;
    logic [31:0]   addr;
    logic [3:0]    width;
    logic [DW-1:0] wdata, rdata;
    logic [31:0]   e;
    logic [32:0]   r;
    cksum_engine #(.DATA_W(DW), .ADDR_W(32), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .field_start_i(fs),
      .field_len_i(flen), .dst_field_start_i(dst), .mem_ce_o(ce), .mem_we_o(we),
      .mem_addr_o(addr), .mem_width_o(width), .mem_data_o(wdata), .mem_data_i(rdata),
      .busy_o(busy), .ready_o(ready), .ok_o(ok));
    always_comb begin
      rdata = '0;
      for (int k = 0; k < BY; k++) rdata[DW-1-8*k -: 8] = mem[g][8'(addr + 32'(k))];
    end
    assign rdy[g]  = ready;
    assign outs[g] = {ce, we, busy, ready, ok, width, |{addr, wdata}};
    initial ready_q = 0;
    always @(negedge clk) begin
      if (ce && we) begin
        if (exp_w[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write dw=%0d actual addr %h data %h required none", DW, addr, wdata[15:0]);
        end else begin
          e = exp_w[g].pop_front();
          check($sformatf("write dw=%0d", DW), {width, addr[15:0], wdata[15:0]}, {4'd2, e});
        end
        mem[g][addr[7:0]] = wdata[15:8];
        mem[g][8'(addr[7:0] + 8'd1)] = wdata[7:0];
      end
      if (ready && !ready_q) begin
        if (exp_r[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dw=%0d actual ok %0d required none", DW, ok);
        end else begin
          r = exp_r[g].pop_front();
          check($sformatf("ok_latency dw=%0d", DW), {ok, 32'(cyc - t0)}, r);
        end
      end
      ready_q = ready;
    end
  end
  task automatic load(input int base, input logic [7:0] b[$]);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < b.size(); i++) mem[g][8'(base + i)] = b[i];
  endtask
  task automatic expect_op(input logic m, input logic [15:0] l, input logic [31:0] d,
                           input logic [15:0] wr, input logic eok);
    for (int g = 0; g < 3; g++) begin
      int n = (int'(l) + (2 << g) - 1) / (2 << g);
      if (!m) begin
        exp_w[g].push_back({d[15:0], 16'h0000});
        exp_w[g].push_back({d[15:0], wr});
      end
      exp_r[g].push_back({eok, 32'(m ? n + 1 : n + 3)});
    end
  endtask
  task automatic wait_done(input int hold);
    for (int i = 0; i < 300 && rdy != 3'b111; i++) @(negedge clk);
    check("all_ready", rdy, 3'b111);
    repeat (hold) @(negedge clk);
    start = 0;
    @(negedge clk);
    check("ready_fall", rdy, 3'b000);
  endtask
  task automatic run(input logic m, input logic [31:0] f, input logic [15:0] l, input logic [31:0] d,
                     input logic [15:0] wr, input logic eok, input int hold);
    expect_op(m, l, d, wr, eok);
    @(negedge clk);
    mode = m; fs = f; flen = l; dst = d; start = 1; t0 = cyc + 1;
    wait_done(hold);
  endtask
  initial begin
    for (int g = 0; g < 3; g++) for (int a = 0; a < 256; a++) mem[g][a] = 8'hFF;
    load(32'h20, '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'h12, 8'h34, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7});
    load(32'h40, '{8'h01, 8'h02, 8'h03});
    load(32'h50, '{8'hFF, 8'hFF, 8'h00, 8'h01});
    load(32'h91, '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC});
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check("reset_outputs", outs[g], 10'd0);
    rst = 0;
    run(0, 32'h20, 16'd20, 32'h2A, 16'hB861, 0, 0);
    run(1, 32'h20, 16'd20, 32'h00, 16'h0000, 1, 0);
    for (int g = 0; g < 3; g++) mem[g][8'h20] = 8'h46;
    run(1, 32'h20, 16'd20, 32'h00, 16'h0000, 0, 0);
    for (int g = 0; g < 3; g++) mem[g][8'h20] = 8'h45;
    run(0, 32'h40, 16'd3, 32'h80, 16'hFBFD, 0, 0);
    run(0, 32'h50, 16'd4, 32'h82, 16'hFFFE, 0, 0);
    run(0, 32'h60, 16'd0, 32'h84, 16'hFFFF, 0, 0);
    run(0, 32'h91, 16'd6, 32'h88, 16'hFC96, 0, 5);
    for (int g = 0; g < 3; g++) exp_w[g].push_back({16'h002A, 16'h0000});
    @(negedge clk);
    mode = 0; fs = 32'h20; flen = 16'd20; dst = 32'h2A; start = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("abort_outputs", outs[g], 10'd0);
    expect_op(0, 16'd20, 32'h2A, 16'hB861, 0);
    rst = 0; t0 = cyc + 1;
    wait_done(0);
    for (int g = 0; g < 3; g++) begin
      check("writes_drained", 64'(exp_w[g].size()), 64'd0);
      check("readies_drained", 64'(exp_r[g].size()), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
